// File: rtl/bios_mem_seq.sv
// Memory-access sequencer behind the BIOS command parser: collects address/length/data
// bytes from the host, issues word RAM accesses, streams read data and a status byte back.
module bios_mem_seq #(
  parameter logic [7:0] ACK_CODE = 8'h4B,
  parameter logic [7:0] ERR_CODE = 8'h41
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        cmd_start,
  input  logic        cmd_is_write,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_in_ready,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_out_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_WDATA, S_WREQ, S_RREQ, S_RSEND, S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  status_q, status_d;

  logic        in_fire, out_fire, ack_fire;
  logic [15:0] len_full;

  assign o_in_ready = (state_q == S_ADDR) || (state_q == S_LEN) || (state_q == S_WDATA);
  assign o_valid    = (state_q == S_RSEND) || (state_q == S_RESP);
  assign mem_req    = (state_q == S_WREQ) || (state_q == S_RREQ);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = (state_q != S_IDLE);

  assign in_fire  = clk_en & i_valid & o_in_ready;
  assign out_fire = clk_en & o_valid & i_out_ready;
  assign ack_fire = clk_en & mem_ack & mem_req;
  assign done     = ~rst & out_fire & (state_q == S_RESP);
  // Full count as it will stand once the high byte lands, so LEN can branch on this edge.
  assign len_full = {i_data, len_q[7:0]};

  always_comb begin
    o_data = 8'h00;
    if (state_q == S_RSEND)
      o_data = rdata_q[{cnt_q, 3'b000} +: 8];
    else if (state_q == S_RESP)
      o_data = status_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    len_d    = len_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (clk_en && cmd_start) begin
          we_d    = cmd_is_write;
          cnt_d   = 2'd0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (in_fire) begin
          addr_d[{cnt_q, 3'b000} +: 8] = i_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (in_fire) begin
          if (!cnt_q[0]) begin
            len_d[7:0] = i_data;
            cnt_d      = 2'd1;
          end else begin
            len_d[15:8] = i_data;
            cnt_d       = 2'd0;
            if (addr_q[1:0] != 2'b00) begin
              status_d = ERR_CODE;
              state_d  = S_RESP;
            end else if (len_full == 16'd0) begin
              status_d = ACK_CODE;
              state_d  = S_RESP;
            end else begin
              state_d = we_q ? S_WDATA : S_RREQ;
            end
          end
        end
      end
      S_WDATA: begin
        if (in_fire) begin
          wdata_d[{cnt_q, 3'b000} +: 8] = i_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_WREQ;
        end
      end
      S_WREQ: begin
        if (ack_fire) begin
          addr_d = addr_q + 32'd4;
          len_d  = len_q - 16'd1;
          if (len_q == 16'd1) begin
            status_d = ACK_CODE;
            state_d  = S_RESP;
          end else begin
            state_d = S_WDATA;
          end
        end
      end
      S_RREQ: begin
        if (ack_fire) begin
          rdata_d = mem_rdata;
          cnt_d   = 2'd0;
          state_d = S_RSEND;
        end
      end
      S_RSEND: begin
        if (out_fire) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            addr_d = addr_q + 32'd4;
            len_d  = len_q - 16'd1;
            if (len_q == 16'd1) begin
              status_d = ACK_CODE;
              state_d  = S_RESP;
            end else begin
              state_d = S_RREQ;
            end
          end
        end
      end
      S_RESP: begin
        if (out_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      len_q    <= 16'd0;
      status_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      len_q    <= len_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_bios_mem_seq.sv
// Bench for bios_mem_seq: a host/RAM transaction model predicts the byte stream and the
// access list of each command; directed cases first, then randomized commands.
module tb_bios_mem_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b0;
  logic        cmd_start = 1'b0;
  logic        cmd_is_write = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        i_valid = 1'b0;
  logic        o_in_ready;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        i_out_ready = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic        done;

  bios_mem_seq dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .cmd_start(cmd_start), .cmd_is_write(cmd_is_write),
    .i_data(i_data), .i_valid(i_valid), .o_in_ready(o_in_ready),
    .o_data(o_data), .o_valid(o_valid), .i_out_ready(i_out_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  logic [31:0] wd_w[$];
  logic [31:0] rd_w[$];

  task automatic check_all_zero(input string tag);
    check_val({tag, "_in_ready"}, 32'(o_in_ready), 32'd0);
    check_val({tag, "_o_valid"},  32'(o_valid),    32'd0);
    check_val({tag, "_o_data"},   32'(o_data),     32'd0);
    check_val({tag, "_mem_req"},  32'(mem_req),    32'd0);
    check_val({tag, "_mem_we"},   32'(mem_we),     32'd0);
    check_val({tag, "_mem_addr"}, mem_addr,        32'd0);
    check_val({tag, "_mem_wdata"}, mem_wdata,      32'd0);
    check_val({tag, "_busy"},     32'(busy),       32'd0);
    check_val({tag, "_done"},     32'(done),       32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    clk_en = 1'($urandom_range(0, 1));
    cmd_start = 1'b0;
    i_valid = 1'b0;
    i_out_ready = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clk_en = 1'b0;
    #1;
    check_all_zero(tag);
  endtask

  // abort_mode: 0 run to completion, 1 stop after 8 input bytes, 2 stop at first mem_req (never acked)
  task automatic run_cmd(input bit we, input logic [31:0] addr, input int cnt,
                         input bit stress, input int stall, input int abort_mode);
    logic [7:0]  in_q[$];
    logic [7:0]  exp_out[$];
    acc_t        exp_acc[$];
    acc_t        a;
    logic [15:0] c16;
    logic [31:0] w;
    logic [7:0]  od, prev_od;
    bit aligned, en, iv, ory, ack, ov, oir, mr, prev_pend;
    int in_idx, out_idx, acc_idx, cyc, done_cnt, req_cycles, stall_left;

    aligned = (addr[1:0] == 2'b00);
    c16 = 16'(cnt);
    in_idx = 0; out_idx = 0; acc_idx = 0; cyc = 0; done_cnt = 0; req_cycles = 0;
    stall_left = stall; prev_pend = 1'b0; prev_od = 8'h00;

    for (int b = 0; b < 4; b++) in_q.push_back(addr[8*b +: 8]);
    in_q.push_back(c16[7:0]);
    in_q.push_back(c16[15:8]);
    while (wd_w.size() < cnt) wd_w.push_back($urandom);
    while (rd_w.size() < cnt) rd_w.push_back($urandom);
    if (aligned && cnt > 0) begin
      for (int i = 0; i < cnt; i++) begin
        a.we = we;
        a.addr = addr + 32'(4 * i);
        a.data = we ? wd_w[i] : 32'd0;
        exp_acc.push_back(a);
        w = we ? wd_w[i] : rd_w[i];
        for (int b = 0; b < 4; b++) begin
          if (we) in_q.push_back(w[8*b +: 8]);
          else    exp_out.push_back(w[8*b +: 8]);
        end
      end
    end
    exp_out.push_back(aligned ? 8'h4B : 8'h41);

    @(negedge clk);
    check_val("idle_busy", 32'(busy), 32'd0);
    cmd_start = 1'b1;
    cmd_is_write = we;
    clk_en = 1'b1;
    i_valid = 1'b0;
    i_out_ready = 1'b0;
    mem_ack = 1'b0;

    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin
        check_val("timeout_out_idx", 32'(out_idx), 32'(exp_out.size()));
        break;
      end
      ov = o_valid; oir = o_in_ready; mr = mem_req; od = o_data;
      en = stress ? ($urandom_range(0, 2) != 0) : 1'b1;
      cmd_start = ($urandom_range(0, 7) == 0);
      cmd_is_write = 1'($urandom_range(0, 1));
      iv = (in_idx < in_q.size()) && (!stress || $urandom_range(0, 1) == 1);
      i_valid = iv;
      i_data = iv ? in_q[in_idx] : 8'($urandom);
      ack = mr && (abort_mode != 2) && ($urandom_range(0, 1) == 1);
      mem_ack = ack;
      mem_rdata = (acc_idx < rd_w.size()) ? rd_w[acc_idx] : $urandom;
      if (ov && stall_left > 0) begin
        ory = 1'b0;
        stall_left--;
      end else begin
        ory = stress ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      i_out_ready = ory;
      clk_en = en;
      #1;
      check_val("done", 32'(done), 32'(en && ov && ory && (out_idx == exp_out.size() - 1)));
      if (done) done_cnt++;
      if (mr) req_cycles++;
      if (prev_pend && ov) check_val("o_data_hold", 32'(od), 32'(prev_od));
      if (en && oir && iv) in_idx++;
      if (en && mr && ack) begin
        if (acc_idx < exp_acc.size()) begin
          check_val("mem_we", 32'(mem_we), 32'(exp_acc[acc_idx].we));
          check_val("mem_addr", mem_addr, exp_acc[acc_idx].addr);
          if (we) check_val("mem_wdata", mem_wdata, exp_acc[acc_idx].data);
        end else begin
          check_val("extra_access", 32'(acc_idx), 32'(exp_acc.size()));
        end
        acc_idx++;
      end
      prev_pend = ov && !(en && ory);
      prev_od = od;
      if (en && ov && ory) begin
        if (out_idx < exp_out.size()) check_val("o_data", 32'(od), 32'(exp_out[out_idx]));
        out_idx++;
      end
      if (out_idx >= exp_out.size()) break;
      if (abort_mode == 1 && in_idx >= 8) break;
      if (abort_mode == 2 && mr) break;
    end

    if (abort_mode == 0) begin
      @(negedge clk);
      cmd_start = 1'b0;
      clk_en = 1'b1;
      i_valid = 1'b0;
      i_out_ready = 1'b0;
      mem_ack = 1'b0;
      #1;
      check_val("end_busy", 32'(busy), 32'd0);
      check_val("end_o_valid", 32'(o_valid), 32'd0);
      check_val("end_mem_req", 32'(mem_req), 32'd0);
      check_val("in_consumed", 32'(in_idx), 32'(in_q.size()));
      check_val("access_count", 32'(acc_idx), 32'(exp_acc.size()));
      check_val("done_pulses", 32'(done_cnt), 32'd1);
      if (exp_acc.size() == 0) check_val("no_mem_req", 32'(req_cycles), 32'd0);
    end
  endtask

  logic [31:0] raddr;

  initial begin
    do_reset("reset");

    wd_w = {32'h12345678};
    run_cmd(1'b1, 32'h0000_0100, 1, 1'b0, 0, 0);

    wd_w.delete(); rd_w = {32'hAABBCCDD, 32'h11223344};
    run_cmd(1'b0, 32'h0000_0200, 2, 1'b0, 0, 0);

    rd_w.delete();
    run_cmd(1'b0, 32'h0000_0101, 3, 1'b0, 0, 0);
    run_cmd(1'b1, 32'h0000_0103, 2, 1'b1, 0, 0);

    wd_w = {32'hCAFEF00D, 32'h0BADBEEF};
    run_cmd(1'b1, 32'hFFFF_FFFC, 2, 1'b0, 0, 0);
    wd_w.delete();
    run_cmd(1'b1, 32'h0000_0400, 0, 1'b0, 0, 0);

    rd_w.delete();
    run_cmd(1'b0, 32'h0000_1000, 3, 1'b1, 5, 0);

    run_cmd(1'b1, 32'h0000_2000, 2, 1'b0, 0, 1);
    do_reset("rst_wdata");
    wd_w = {32'h5A5AA5A5};
    run_cmd(1'b1, 32'h0000_3000, 1, 1'b0, 0, 0);

    wd_w.delete();
    run_cmd(1'b1, 32'h0000_4000, 1, 1'b0, 0, 2);
    do_reset("rst_req");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      clk_en = 1'b1;
      mem_ack = 1'b1;
      #1;
      check_val("late_ack_req", 32'(mem_req), 32'd0);
      check_val("late_ack_busy", 32'(busy), 32'd0);
      check_val("late_ack_valid", 32'(o_valid), 32'd0);
    end
    mem_ack = 1'b0;

    for (int t = 0; t < 25; t++) begin
      wd_w.delete(); rd_w.delete();
      case ($urandom_range(0, 9))
        0: raddr = $urandom | 32'h1;
        1: raddr = 32'hFFFF_FFF0 | {28'd0, 2'($urandom_range(0, 3)), 2'b00};
        default: raddr = $urandom & 32'hFFFF_FFFC;
      endcase
      run_cmd(1'($urandom_range(0, 1)), raddr, $urandom_range(0, 4),
              1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
